// File: rtl/tap_tempo_meter_pkg.sv
// Shared constants and FSM encoding for the tap-tempo meter and the tempo divider.
package tap_tempo_meter_pkg;

  localparam int TTM_DEFAULT_CNT = 99;
  localparam int TTM_CNT_MIN     = 4;
  localparam int TTM_LOCKOUT     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } ttm_state_e;

endpackage

// File: rtl/tap_conditioner.sv
// Synchronizes the raw tap button, detects rising edges and applies a debounce
// lockout, emitting a single-cycle tap_pulse per accepted press.
module tap_conditioner
  import tap_tempo_meter_pkg::*;
#(
  parameter int LOCKOUT = TTM_LOCKOUT
) (
  input  logic before_clk,
  input  logic rstn,
  input  logic tap,
  input  logic en,
  output logic tap_pulse
);

  localparam int LOCK_W = $clog2(LOCKOUT + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT);

  logic              sync1;
  logic              sync2;
  logic              sync3;
  logic              tap_edge;
  logic [LOCK_W-1:0] lockout;

  assign tap_edge  = sync2 & ~sync3;
  assign tap_pulse = tap_edge & en & (lockout == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // synchronizer chain into a single flop.
  always_ff @(posedge before_clk or negedge rstn) begin
    if (!rstn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      lockout <= '0;
    end else begin
      sync1 <= tap;
      sync2 <= sync1;
      sync3 <= sync2;
      if (tap_pulse) begin
        lockout <= LOCK_LOAD;
      end else if (lockout != '0) begin
        lockout <= lockout - LOCK_W'(1);
      end
    end
  end

endmodule

// File: rtl/tap_tempo_meter.sv
// Measures the spacing of accepted taps, keeps a rolling history and converts
// the averaged interval into the half-period count used by the tempo divider.
module tap_tempo_meter
  import tap_tempo_meter_pkg::*;
#(
  parameter int IVL_W       = 10,
  parameter int AVG_LOG2    = 2,
  parameter int LOCKOUT     = TTM_LOCKOUT,
  parameter int CNT_MIN     = TTM_CNT_MIN,
  parameter int DEFAULT_CNT = TTM_DEFAULT_CNT
) (
  input  logic             before_clk,
  input  logic             rstn,
  input  logic             tap,
  input  logic [2:0]       state,
  input  logic [2:0]       line1,
  output logic [IVL_W-2:0] cnt_max,
  output logic             cnt_valid,
  output logic             cnt_update,
  output logic             tap_ack
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = IVL_W + AVG_LOG2;
  localparam int CNT_W = IVL_W - 1;

  localparam logic [IVL_W-1:0]    IVL_MAX   = '1;
  localparam logic [IVL_W-1:0]    IVL_ONE   = IVL_W'(1);
  localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
  localparam logic [AVG_LOG2:0]   FILL_ONE  = (AVG_LOG2 + 1)'(1);
  localparam logic [CNT_W-1:0]    CNT_FLOOR = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0]    CNT_RESET = CNT_W'(DEFAULT_CNT);

  logic             en;
  logic             tap_pulse;
  ttm_state_e       fsm_q;
  ttm_state_e       fsm_d;
  logic [IVL_W-1:0] ivl;
  logic [IVL_W-1:0] ivl_d;
  logic             push;
  logic             flush;
  logic [IVL_W-1:0] hist [DEPTH];
  logic [AVG_LOG2:0] fill;
  logic             calc_pending;
  logic             calc_fire;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] raw;
  logic [CNT_W-1:0] cnt_next;

  assign en = (state < line1);

  tap_conditioner #(
    .LOCKOUT (LOCKOUT)
  ) u_cond (
    .before_clk (before_clk),
    .rstn       (rstn),
    .tap        (tap),
    .en         (en),
    .tap_pulse  (tap_pulse)
  );

  // NOTE: every signal driven here gets a default before any branch so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    ivl_d = ivl;
    push  = 1'b0;
    flush = 1'b0;
    if (!en) begin
      fsm_d = IDLE;
      flush = 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (tap_pulse) begin
            fsm_d = ARMED;
            ivl_d = IVL_ONE;
          end
        end
        ARMED: begin
          // A tap landing on the timeout cycle is discarded with the history.
          if (ivl == IVL_MAX) begin
            fsm_d = IDLE;
            flush = 1'b1;
          end else if (tap_pulse) begin
            push  = 1'b1;
            ivl_d = IVL_ONE;
          end else begin
            ivl_d = ivl + IVL_ONE;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge before_clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q <= IDLE;
      ivl   <= '0;
    end else begin
      fsm_q <= fsm_d;
      ivl   <= ivl_d;
    end
  end

  // NOTE: the history is reset explicitly because a partial refill after a
  // flush must never average in stale intervals.
  always_ff @(posedge before_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      fill         <= '0;
      calc_pending <= 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        fill <= '0;
      end else if (push) begin
        hist[0] <= ivl;
        for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
        if (fill != FILL_FULL) fill <= fill + FILL_ONE;
      end
      calc_pending <= push && (fill >= FILL_FULL - FILL_ONE);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < DEPTH; i++) sum = sum + SUM_W'(hist[i]);
  end

  // avg >> 1 folded into a single shift of the sum.
  assign half      = CNT_W'(sum >> (AVG_LOG2 + 1));
  assign raw       = (half == '0) ? '0 : half - CNT_W'(1);
  assign cnt_next  = (raw < CNT_FLOOR) ? CNT_FLOOR : raw;
  assign calc_fire = calc_pending & en;

  always_ff @(posedge before_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_max    <= CNT_RESET;
      cnt_valid  <= 1'b0;
      cnt_update <= 1'b0;
      tap_ack    <= 1'b0;
    end else begin
      tap_ack    <= tap_pulse;
      cnt_update <= calc_fire;
      if (calc_fire) begin
        cnt_max   <= cnt_next;
        cnt_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tap_tempo_meter.sv
// Randomized and directed stimulus for tap_tempo_meter, checked every cycle
// against a timestamp-based model of tap acceptance and interval averaging.
module tb_tap_tempo_meter;

  localparam int IVL_W       = 10;
  localparam int AVG_LOG2    = 2;
  localparam int LOCKOUT     = 8;
  localparam int CNT_MIN     = 4;
  localparam int DEFAULT_CNT = 99;
  localparam int DEPTH       = 1 << AVG_LOG2;
  localparam int IVL_LIMIT   = (1 << IVL_W) - 1;

  logic       before_clk = 1'b0;
  logic       rstn       = 1'b0;
  logic       tap        = 1'b0;
  logic [2:0] state      = 3'd0;
  logic [2:0] line1      = 3'd3;
  logic [8:0] cnt_max;
  logic       cnt_valid;
  logic       cnt_update;
  logic       tap_ack;

  tap_tempo_meter #(
    .IVL_W       (IVL_W),
    .AVG_LOG2    (AVG_LOG2),
    .LOCKOUT     (LOCKOUT),
    .CNT_MIN     (CNT_MIN),
    .DEFAULT_CNT (DEFAULT_CNT)
  ) dut (
    .before_clk (before_clk),
    .rstn       (rstn),
    .tap        (tap),
    .state      (state),
    .line1      (line1),
    .cnt_max    (cnt_max),
    .cnt_valid  (cnt_valid),
    .cnt_update (cnt_update),
    .tap_ack    (tap_ack)
  );

  always #5 before_clk = ~before_clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: taps are time-stamped by cycle number; an interval is simply the
  // difference of two accepted timestamps.
  int  cyc      = 0;
  bit  s1 = 0, s2 = 0, s3 = 0;
  int  last_acc = -1000;
  bit  armed    = 0;
  int  arm_ref  = 0;
  int  ivq[$];
  bit  pending  = 0;
  int  m_cnt    = DEFAULT_CNT;
  bit  m_valid  = 0;
  bit  m_upd    = 0;
  bit  m_ack    = 0;

  always @(posedge before_clk) begin
    cyc++;
    if (!rstn) begin
      s1 = 0; s2 = 0; s3 = 0;
      last_acc = cyc - 1000;
      armed = 0; pending = 0; ivq.delete();
      m_cnt = DEFAULT_CNT; m_valid = 0; m_upd = 0; m_ack = 0;
    end else begin
      bit en_m, acc;
      int sum, val;
      en_m = (state < line1);
      acc  = s2 && !s3 && en_m && (cyc - last_acc > LOCKOUT);
      if (acc) last_acc = cyc;
      m_ack = acc;
      m_upd = 0;
      if (pending && en_m) begin
        sum = 0;
        foreach (ivq[i]) sum += ivq[i];
        val = (sum / DEPTH) / 2 - 1;
        m_cnt   = (val < CNT_MIN) ? CNT_MIN : val;
        m_upd   = 1;
        m_valid = 1;
      end
      pending = 0;
      if (!en_m) begin
        armed = 0; ivq.delete();
      end else if (armed && (cyc - arm_ref >= IVL_LIMIT)) begin
        armed = 0; ivq.delete();
      end else if (acc) begin
        if (armed) begin
          ivq.push_front(cyc - arm_ref);
          if (ivq.size() > DEPTH) void'(ivq.pop_back());
          pending = (ivq.size() == DEPTH);
        end
        armed   = 1;
        arm_ref = cyc;
      end
      s3 = s2; s2 = s1; s1 = tap;
    end
  end

  always @(negedge before_clk) begin
    if (rstn) begin
      check("tap_ack",    tap_ack,    m_ack);
      check("cnt_update", cnt_update, m_upd);
      check("cnt_max",    cnt_max,    m_cnt);
      check("cnt_valid",  cnt_valid,  m_valid);
    end
  end

  int ack_cnt = 0;
  int upd_cnt = 0;
  always @(posedge before_clk) begin
    if (rstn && tap_ack)    ack_cnt++;
    if (rstn && cnt_update) upd_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge before_clk);
  endtask

  task automatic tap_train(input int n, input int gap, input bit bounce);
    for (int i = 0; i < n; i++) begin
      if (bounce) begin
        for (int b = 0; b < 3; b++) begin
          tap = 1'b1; wait_cycles(1);
          tap = 1'b0; wait_cycles(1);
        end
        wait_cycles(gap - 6);
      end else begin
        tap = 1'b1; wait_cycles(3);
        tap = 1'b0; wait_cycles(gap - 3);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, u0;
    wait_cycles(3);
    check("reset cnt_max",    cnt_max,    DEFAULT_CNT);
    check("reset cnt_valid",  cnt_valid,  0);
    check("reset cnt_update", cnt_update, 0);
    check("reset tap_ack",    tap_ack,    0);
    rstn = 1'b1;
    wait_cycles(5);

    // Four taps at 200: acks but no average yet; the fifth completes it.
    a0 = ack_cnt; u0 = upd_cnt;
    tap_train(4, 200, 0);
    check("first4 acks",    ack_cnt - a0, 4);
    check("first4 updates", upd_cnt - u0, 0);
    tap_train(1, 200, 0);
    check("fifth acks",    ack_cnt - a0, 5);
    check("fifth updates", upd_cnt - u0, 1);
    check("avg200 cnt_max", cnt_max, 99);
    check("avg200 valid",   cnt_valid, 1);

    // Sixth tap 1000 cycles later: (3*200+1000)/4 = 400 -> 199.
    wait_cycles(800);
    tap_train(1, 12, 0);
    check("rolling cnt_max", cnt_max, 199);

    tap_train(5, 12, 0);
    check("avg12 cnt_max", cnt_max, 5);
    tap_train(5, 10, 0);
    check("avg10 cnt_max", cnt_max, 4);
    tap_train(5, 9, 0);
    check("avg9 clamp cnt_max", cnt_max, 4);

    // Bouncing presses: one ack each, intervals from the first edge.
    a0 = ack_cnt;
    tap_train(5, 40, 1);
    check("bounce acks",    ack_cnt - a0, 5);
    check("bounce cnt_max", cnt_max, 19);

    // Timeout after two taps leaves outputs alone and empties the history.
    wait_cycles(1100);
    u0 = upd_cnt;
    tap_train(2, 200, 0);
    wait_cycles(900);
    check("timeout updates", upd_cnt - u0, 0);
    check("timeout cnt_max", cnt_max, 19);
    check("timeout valid",   cnt_valid, 1);
    tap_train(5, 300, 0);
    check("after timeout updates", upd_cnt - u0, 1);
    check("avg300 cnt_max", cnt_max, 149);

    // Disable mid-sequence, then re-enable: a full refill is needed.
    wait_cycles(1100);
    tap_train(3, 100, 0);
    state = 3'd3;
    a0 = ack_cnt;
    tap_train(3, 100, 0);
    check("disabled acks",    ack_cnt - a0, 0);
    check("disabled cnt_max", cnt_max, 149);
    state = 3'd0;
    u0 = upd_cnt;
    tap_train(4, 100, 0);
    check("refill updates", upd_cnt - u0, 0);
    tap_train(1, 100, 0);
    check("refill done updates", upd_cnt - u0, 1);
    check("avg100 cnt_max", cnt_max, 49);

    // Random taps, gaps, widths, bounces and enable changes.
    for (int i = 0; i < 150; i++) begin
      int gap, width;
      if ($urandom_range(9) == 0) begin
        line1 = 3'($urandom_range(1, 7));
        state = ($urandom_range(3) == 0) ? 3'($urandom_range(int'(line1), 7))
                                         : 3'($urandom_range(0, int'(line1) - 1));
      end
      gap = ($urandom_range(7) == 0) ? $urandom_range(900, 1100) : $urandom_range(4, 300);
      if (gap >= 9 && $urandom_range(4) == 0) begin
        tap_train(1, gap, 1);
      end else begin
        width = $urandom_range(1, (gap - 1 < 6) ? gap - 1 : 6);
        tap = 1'b1; wait_cycles(width);
        tap = 1'b0; wait_cycles(gap - width);
      end
    end

    // Asynchronous reset in the middle of a sequence.
    state = 3'd0; line1 = 3'd3;
    tap_train(3, 50, 0);
    @(posedge before_clk);
    #3 rstn = 1'b0;
    #1;
    check("midreset cnt_max",    cnt_max,    DEFAULT_CNT);
    check("midreset cnt_valid",  cnt_valid,  0);
    check("midreset cnt_update", cnt_update, 0);
    check("midreset tap_ack",    tap_ack,    0);
    wait_cycles(3);
    rstn = 1'b1;
    wait_cycles(2);
    tap_train(5, 60, 0);
    check("post reset cnt_max", cnt_max, 29);
    check("post reset valid",   cnt_valid, 1);

    wait_cycles(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
